// File: rtl/dk_sound_pkg.sv
// Shared widths, FSM state type and arithmetic helpers for the Donkey Kong sound mixer.
package dk_sound_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int GAIN_W    = 8;
    localparam int GAIN_FRAC = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        SAT  = 2'd2,
        DONE = 2'd3
    } mix_state_t;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] val;
        logic                       clip;
    } sat_t;

    // Headroom for NUM_CH full-scale 16x8 products summed without wrapping.
    function automatic int acc_width(input int num_ch);
        return SAMPLE_W + GAIN_W + $clog2(num_ch);
    endfunction

    function automatic sat_t sat16(input logic signed [31:0] s);
        sat_t r;
        if (s > 32'sd32767) begin
            r.val  = 16'sh7fff;
            r.clip = 1'b1;
        end else if (s < -32'sd32768) begin
            r.val  = 16'sh8000;
            r.clip = 1'b1;
        end else begin
            r.val  = s[SAMPLE_W-1:0];
            r.clip = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/dk_sound_mixer_if.sv
// Sample/gain/mute inputs and mixed-sample status outputs of the sound mixer.
interface dk_sound_mixer_if #(
    parameter int NUM_CH = 4
);
    import dk_sound_pkg::*;

    logic                         audio_clk_en;
    logic [NUM_CH*SAMPLE_W-1:0]   ch_in;
    logic [NUM_CH*GAIN_W-1:0]     gain;
    logic [NUM_CH-1:0]            mute;
    logic signed [SAMPLE_W-1:0]   out;
    logic                         out_valid;
    logic                         clip;
    logic                         busy;
    logic                         overrun;

    modport master (
        output audio_clk_en, ch_in, gain, mute,
        input  out, out_valid, clip, busy, overrun
    );

    modport slave (
        input  audio_clk_en, ch_in, gain, mute,
        output out, out_valid, clip, busy, overrun
    );

endinterface

// File: rtl/dk_sound_mixer.sv
// Time-multiplexed MAC mixer: one channel per cycle, then floor shift, saturate and publish.
module dk_sound_mixer
    import dk_sound_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CLOCK_RATE  = 1000000,
    parameter int SAMPLE_RATE = 48000
) (
    input  logic             clk,
    input  logic             I_RST,
    dk_sound_mixer_if.slave  bus
);

    localparam int ACC_W = acc_width(NUM_CH);
    localparam int IDX_W = $clog2(NUM_CH);

    if (NUM_CH < 2 || NUM_CH > 8) begin : g_ch_chk
        $error("dk_sound_mixer: NUM_CH must be in 2..8");
    end
    if (CLOCK_RATE / SAMPLE_RATE < NUM_CH + 3) begin : g_rate_chk
        $error("dk_sound_mixer: too few clocks per audio tick for NUM_CH");
    end

    mix_state_t                  state_q, state_d;
    logic [IDX_W-1:0]            idx;
    logic signed [ACC_W-1:0]     acc;
    sat_t                        sat_r;
    logic signed [SAMPLE_W-1:0]  out_q;
    logic                        clip_q;
    logic                        out_valid_q;
    logic                        overrun_q;

    logic signed [SAMPLE_W-1:0]  ch_snap   [NUM_CH];
    logic [GAIN_W-1:0]           gain_snap [NUM_CH];
    logic [NUM_CH-1:0]           mute_snap;

    logic                        start;
    logic                        last_ch;
    logic signed [23:0]          prod;

    assign start   = (state_q == IDLE) && bus.audio_clk_en;
    assign last_ch = (idx == IDX_W'(NUM_CH - 1));

    // Gain is unsigned Q1.7, so it enters the signed multiplier zero-extended.
    assign prod = mute_snap[idx] ? 24'sd0
                : 24'(ch_snap[idx]) * 24'($signed({1'b0, gain_snap[idx]}));

    always_ff @(posedge clk) begin
        if (I_RST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.audio_clk_en) state_d = MAC;
            MAC:     if (last_ch) state_d = SAT;
            SAT:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Snapshot is pure data; it is only consumed after a fresh capture.
    always_ff @(posedge clk) begin
        if (start) begin
            for (int k = 0; k < NUM_CH; k++) begin
                ch_snap[k]   <= $signed(bus.ch_in[SAMPLE_W*k +: SAMPLE_W]);
                gain_snap[k] <= bus.gain[GAIN_W*k +: GAIN_W];
            end
            mute_snap <= bus.mute;
        end
    end

    always_ff @(posedge clk) begin
        if (I_RST) begin
            acc         <= '0;
            idx         <= '0;
            sat_r       <= '0;
            out_q       <= '0;
            clip_q      <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (bus.audio_clk_en && state_q != IDLE) overrun_q <= 1'b1;
            case (state_q)
                IDLE: if (bus.audio_clk_en) begin
                    acc <= '0;
                    idx <= '0;
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    idx <= idx + 1'b1;
                end
                SAT:  sat_r <= sat16(32'(acc >>> GAIN_FRAC));
                DONE: begin
                    out_q       <= sat_r.val;
                    clip_q      <= sat_r.clip;
                    out_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.out       = out_q;
    assign bus.clip      = clip_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dk_sound_mixer.sv
// Directed and back-to-back checks of dk_sound_mixer with NUM_CH=4.
module tb_dk_sound_mixer;

    localparam int NCH = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dk_sound_mixer_if #(.NUM_CH(NCH)) bus ();

    dk_sound_mixer #(
        .NUM_CH      (NCH),
        .CLOCK_RATE  (1000000),
        .SAMPLE_RATE (48000)
    ) dut (
        .clk   (clk),
        .I_RST (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.ch_in = '0;
        bus.gain  = '0;
        bus.mute  = '0;
    endtask

    task automatic set_ch(input int k, input int v, input int g, input bit m);
        bus.ch_in[16*k +: 16] = 16'(v);
        bus.gain[8*k +: 8]    = 8'(g);
        bus.mute[k]           = m;
    endtask

    // One tick, then watch a bounded window for the single result pulse.
    task automatic pass_check(input string tag, input int exp_out, input int exp_clip);
        int lat = -1;
        int o = 0;
        int c = 0;
        int pulses = 0;
        @(negedge clk);
        bus.audio_clk_en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            bus.audio_clk_en = 1'b0;
            if (bus.out_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    o   = bus.out;
                    c   = bus.clip;
                end
            end
        end
        check({tag, "_lat"}, lat, 7);
        check({tag, "_out"}, o, exp_out);
        check({tag, "_clip"}, c, exp_clip);
        check({tag, "_pulses"}, pulses, 1);
    endtask

    function automatic int model(input logic [63:0] chv, input logic [31:0] gv,
                                 input logic [3:0] mv, output int clip_o);
        longint s = 0;
        for (int k = 0; k < NCH; k++)
            if (!mv[k]) s += longint'($signed(chv[16*k +: 16])) * longint'(gv[8*k +: 8]);
        s = s >>> 7;
        clip_o = 1;
        if (s > 32767)  return 32767;
        if (s < -32768) return -32768;
        clip_o = 0;
        return int'(s);
    endfunction

    initial begin
        int pulses;
        int ticks;
        int q_out[$];
        int q_clip[$];
        int exp_c;
        int exp_o;

        rst = 1'b1;
        bus.audio_clk_en = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        check("rst_out", bus.out, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_clip", bus.clip, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_overrun", bus.overrun, 0);
        rst = 1'b0;

        set_ch(0, 1000, 128, 0);
        pass_check("unity", 1000, 0);

        clear_inputs();
        set_ch(0, 1000, 64, 0);
        set_ch(1, -2000, 192, 0);
        pass_check("gmix", -2500, 0);
        bus.mute[1] = 1'b1;
        pass_check("mute1", 500, 0);

        clear_inputs();
        set_ch(0, -3, 64, 0);
        pass_check("floor", -2, 0);

        for (int k = 0; k < NCH; k++) set_ch(k, 30000, 255, 0);
        pass_check("sat_pos", 32767, 1);
        for (int k = 0; k < NCH; k++) set_ch(k, -30000, 255, 0);
        pass_check("sat_neg", -32768, 1);
        for (int k = 0; k < NCH; k++) set_ch(k, 30000, 255, 1);
        pass_check("mute_all", 0, 0);

        clear_inputs();
        set_ch(0, 32767, 128, 0);
        pass_check("edge_max", 32767, 0);
        set_ch(0, -32768, 128, 0);
        pass_check("edge_min", -32768, 0);

        // Second tick lands mid-pass; the snapshot must shield the first result.
        set_ch(0, 1000, 128, 0);
        @(negedge clk);
        bus.audio_clk_en = 1'b1;
        @(negedge clk);
        bus.audio_clk_en = 1'b0;
        set_ch(0, 5000, 128, 0);
        check("ovr_busy", bus.busy, 1);
        @(negedge clk);
        bus.audio_clk_en = 1'b1;
        pulses = 0;
        exp_o = 0;
        for (int k = 3; k <= 25; k++) begin
            @(negedge clk);
            bus.audio_clk_en = 1'b0;
            if (bus.out_valid) begin
                pulses++;
                exp_o = bus.out;
            end
        end
        check("ovr_out", exp_o, 1000);
        check("ovr_pulses", pulses, 1);
        check("ovr_flag", bus.overrun, 1);
        pass_check("ovr_next", 5000, 0);
        check("ovr_sticky", bus.overrun, 1);

        // Reset in the middle of a pass.
        set_ch(0, 2000, 128, 0);
        @(negedge clk);
        bus.audio_clk_en = 1'b1;
        @(negedge clk);
        bus.audio_clk_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mrst_out", bus.out, 0);
        check("mrst_valid", bus.out_valid, 0);
        check("mrst_clip", bus.clip, 0);
        check("mrst_busy", bus.busy, 0);
        check("mrst_overrun", bus.overrun, 0);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.out_valid) pulses++;
        end
        check("mrst_no_valid", pulses, 0);

        // Back-to-back ticks at the minimum spacing.
        pulses = 0;
        ticks = 0;
        for (int cyc = 0; cyc < 7*100 + 12; cyc++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                pulses++;
                if (q_out.size() > 0) begin
                    check("b2b_out", bus.out, q_out.pop_front());
                    check("b2b_clip", bus.clip, q_clip.pop_front());
                end else begin
                    check("b2b_extra", 1, 0);
                end
            end
            if (cyc % 7 == 0 && ticks < 100) begin
                bus.ch_in = {$urandom(), $urandom()};
                bus.gain  = $urandom();
                bus.mute  = 4'($urandom_range(0, 15));
                exp_o = model(bus.ch_in, bus.gain, bus.mute, exp_c);
                q_out.push_back(exp_o);
                q_clip.push_back(exp_c);
                bus.audio_clk_en = 1'b1;
                ticks++;
            end else begin
                bus.audio_clk_en = 1'b0;
            end
        end
        check("b2b_pulses", pulses, 100);
        check("b2b_overrun", bus.overrun, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dk_sound_mixer.md
# dk_sound_mixer

Mixes the Donkey Kong discrete sound channels into one signed 16-bit sample per audio tick. It sits directly downstream of the walk circuit and its sibling discrete circuits (jump, stomp, etc.), and upstream of the board audio output. It uses one time-multiplexed multiply-accumulate pass per sample, with per-channel gain, per-channel mute and saturation, and reports overrun and clip status.

## Interface
Parameters:
- NUM_CH, 4, number of input channels (2..8).
- CLOCK_RATE, 1000000, system clock in Hz. Must satisfy CLOCK_RATE/SAMPLE_RATE >= NUM_CH+3.
- SAMPLE_RATE, 48000, audio tick rate in Hz.

Ports:
- clk  in  1  system clock. One clock; all logic on its rising edge.
- I_RST  in  1  reset. Synchronous, active-high.
- audio_clk_en  in  1  one-cycle tick that requests one mixed sample.
- ch_in  in  NUM_CH*16  packed signed samples; channel k = bits [16k+15:16k]. Channel 0 is the walk circuit output.
- gain  in  NUM_CH*8  packed unsigned Q1.7 gains; 128 = unity, 255 ≈ 1.99.
- mute  in  NUM_CH  per-channel mute; 1 forces that channel's contribution to 0.
- out  out  16  signed mixed sample (registered).
- out_valid  out  1  one-cycle pulse when out updates.
- clip  out  1  qualifies out_valid: 1 when the current out was saturated.
- busy  out  1  high while a mix pass is in progress.
- overrun  out  1  sticky; set when a tick arrives while busy.

## Operation
- The FSM has four states: IDLE, MAC, SAT, DONE.
- IDLE:
  - On audio_clk_en, snapshot ch_in, gain and mute into internal registers.
  - Clear the accumulator, set idx=0, go to MAC.
- MAC:
  - One channel per cycle: acc += mute[idx] ? 0 : ch_snap[idx]*gain_snap[idx].
  - After idx=NUM_CH-1, go to SAT.
- SAT:
  - Compute s = acc >>> 7 (arithmetic shift, floor toward −∞).
  - Clamp s to [−32768, 32767]; record clip_next = (clamped ≠ s). Go to DONE.
- DONE: out <= clamped, clip <= clip_next, out_valid=1 for this cycle. Go to IDLE.
- Width rules:
  - Product is 16×9 signed (gain zero-extended), 24-bit result.
  - Accumulator is signed 16+8+clog2(NUM_CH) bits (26 for NUM_CH=4); it never overflows.
- busy = (state ≠ IDLE).
- audio_clk_en while busy (MAC/SAT/DONE) is ignored: the pass in progress continues unaffected and overrun <= 1.
- audio_clk_en in the same cycle as the DONE→IDLE transition counts as busy and is ignored.
- Inputs changing mid-pass have no effect; only the snapshot is used.
- Reset values: out=0, out_valid=0, clip=0, busy=0, overrun=0, state=IDLE, acc=0.
- I_RST asserted mid-pass aborts the pass: no out_valid is produced and out returns to 0.
- overrun clears only on I_RST.

## Timing
- Tick sampled at cycle t. MAC occupies cycles t+1..t+NUM_CH, SAT t+NUM_CH+1, DONE t+NUM_CH+2.
- out, out_valid and clip are visible from t+NUM_CH+3; latency is NUM_CH+3 cycles (7 for NUM_CH=4).
- out holds its value between passes.
- Minimum tick spacing without overrun is NUM_CH+3 cycles.
- At 1 MHz / 48 kHz there are 20 cycles per tick, so NUM_CH ≤ 8 is safe.

## Structure
- Package dk_sound_pkg holds:
  - SAMPLE_W=16, GAIN_W=8, GAIN_FRAC=7.
  - The state enum typedef (IDLE, MAC, SAT, DONE).
  - An acc_width(NUM_CH) function.
  - A sat16 clamp function returning the value plus a clip flag.
- No sub-module. The single multiplier and the accumulator live in this block, since the datapath is one MAC.

## Test plan
- Reset: hold I_RST 3 cycles mid-pass -> out=0, out_valid=0, clip=0, overrun=0, busy=0; no out_valid follows.
- Unity pass-through: ch0=1000, gain0=128, other gains 0, tick at t -> out=1000, out_valid pulse at exactly t+7 (NUM_CH=4), clip=0.
- Gain mix: ch0=1000/g=64, ch1=−2000/g=192, ch2=ch3=0 -> out=−2500. Set mute[1]=1 -> out=500. Odd case ch0=−3/g=64 -> out=−2 (floor).
- Saturation:
  - All ch=30000, g=255 -> out=32767, clip=1.
  - All ch=−30000, g=255 -> out=−32768, clip=1.
  - Accumulator must not wrap.
- Overrun: tick at t, second tick at t+2, and ch_in changed at t+1 -> first result unchanged (from snapshot), only one out_valid, overrun=1 stays set until I_RST.
- Back-to-back: ticks every 7 cycles for 100 ticks with random inputs -> 100 out_valid pulses, overrun=0, every out matches the reference model (floor(sum/128) clamped).
